prbs31_checker: RTL

PRBS31_CHECKER -- requirements
Module: prbs31_checker

---
 rtl/prbs31_pkg.sv | 21 ++
 rtl/prbs31_predict.sv | 27 ++
 rtl/prbs31_checker.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/prbs31_pkg.sv
// -----------------------------------------------------------------------------
// prbs31_pkg
// Shared definitions for the PRBS31 checker: checker state encoding and the
// generator polynomial x^31 + x^28 + 1, given as a history length and two taps.
// The history register keeps the newest bit in bit 0, so bit 30 is the bit
// received 31 bits ago and bit 27 is the bit received 28 bits ago.
// -----------------------------------------------------------------------------
package prbs31_pkg;

  localparam int POLY_LEN = 31;
  localparam int TAP_A    = 30;
  localparam int TAP_B    = 27;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SEED   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

endpackage

// File: rtl/prbs31_predict.sv
// -----------------------------------------------------------------------------
// prbs31_predict
// Combinational PRBS31 step: predicts the next bit from the history register
// and forms the shifted history. The bit shifted in is either the received bit
// (seeding / verifying) or the prediction itself (free-running while locked).
//
// Ports
//   sr       in  [30:0] history register, sr[0] newest
//   din      in         received bit
//   use_pred in         1: shift the prediction in, 0: shift din in
//   pred     out        predicted bit sr[30] ^ sr[27]
//   sr_nxt   out [30:0] history after one shift
// -----------------------------------------------------------------------------
module prbs31_predict
  import prbs31_pkg::*;
(
  input  logic [POLY_LEN-1:0] sr,
  input  logic                din,
  input  logic                use_pred,
  output logic                pred,
  output logic [POLY_LEN-1:0] sr_nxt
);

  assign pred   = sr[TAP_A] ^ sr[TAP_B];
  assign sr_nxt = {sr[POLY_LEN-2:0], (use_pred ? pred : din)};

endmodule

// File: rtl/prbs31_checker.sv
// -----------------------------------------------------------------------------
// prbs31_checker
// Serial PRBS31 (x^31 + x^28 + 1) checker. Hunts for the sequence by seeding a
// 31-bit history from the received stream, verifies LOCK_CNT consecutive
// predictions, then free-runs its own generator while locked so a single line
// error is counted once instead of being multiplied by the feedback taps.
// Lock is dropped when LOSS_THRESH errors land inside one LOSS_WIN-bit window.
//
// Parameters
//   LOCK_CNT    consecutive matches needed in VERIFY to declare lock
//   LOSS_THRESH errors within one window that force loss of lock
//   LOSS_WIN    window length in valid bits
//   CNT_W       width of err_cnt
//
// Ports
//   clk       in         rising-edge clock
//   rst_n     in         synchronous reset, ACTIVE HIGH despite its name
//   din_valid in         din carries a valid bit this cycle
//   din       in         received serial bit, oldest first
//   clr_cnt   in         synchronous clear of err_cnt and bit_cnt
//   locked    out        registered, high while in LOCKED
//   err_pulse out        one-cycle pulse per mismatched bit while locked
//   err_cnt   out [CNT_W] saturating mismatch count while locked
//   bit_cnt   out [32]   wrapping count of bits checked while locked
//
// Build option
//   PRBS31_CHK_BITCNT_EN  when defined, bit_cnt is a live counter; otherwise it
//                         is tied to zero and no counter is built.
// -----------------------------------------------------------------------------
module prbs31_checker
  import prbs31_pkg::*;
#(
  parameter int LOCK_CNT    = 64,
  parameter int LOSS_THRESH = 8,
  parameter int LOSS_WIN    = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [31:0]      bit_cnt
);

  localparam int SC_W = $clog2(POLY_LEN + 1);
  localparam int VC_W = $clog2(LOCK_CNT + 1);
  localparam int WC_W = $clog2(LOSS_WIN + 1);
  localparam int WE_W = $clog2(LOSS_THRESH + 1);

  state_e              state, state_nxt;
  logic [POLY_LEN-1:0] sr, sr_nxt, sr_shift;
  logic [SC_W-1:0]     seed_cnt, seed_nxt;
  logic [VC_W-1:0]     vcnt, vcnt_nxt;
  logic [WC_W-1:0]     win_cnt, win_cnt_nxt;
  logic [WE_W-1:0]     win_err, win_err_nxt, win_err_sum;
  logic                pred, mismatch, err_now;

  prbs31_predict u_predict (
    .sr       (sr),
    .din      (din),
    .use_pred (state == ST_LOCKED),
    .pred     (pred),
    .sr_nxt   (sr_shift)
  );

  assign mismatch    = din ^ pred;
  assign win_err_sum = win_err + WE_W'(mismatch);

  always_comb begin
    state_nxt   = state;
    sr_nxt      = sr;
    seed_nxt    = seed_cnt;
    vcnt_nxt    = vcnt;
    win_cnt_nxt = win_cnt;
    win_err_nxt = win_err;
    err_now     = 1'b0;
    if (din_valid) begin
      sr_nxt = sr_shift;
      case (state)
        ST_HUNT: begin
          state_nxt = ST_SEED;
          seed_nxt  = SC_W'(1);
        end
        ST_SEED: begin
          if (seed_cnt == SC_W'(POLY_LEN - 1)) begin
            // An all-zero history is the PRBS lock-up state; never verify it.
            state_nxt = (sr_shift == '0) ? ST_HUNT : ST_VERIFY;
            seed_nxt  = '0;
            vcnt_nxt  = '0;
          end else begin
            seed_nxt = seed_cnt + 1'b1;
          end
        end
        ST_VERIFY: begin
          if (mismatch) begin
            state_nxt = ST_HUNT;
            vcnt_nxt  = '0;
          end else if (vcnt == VC_W'(LOCK_CNT - 1)) begin
            state_nxt   = ST_LOCKED;
            vcnt_nxt    = '0;
            win_cnt_nxt = '0;
            win_err_nxt = '0;
          end else begin
            vcnt_nxt = vcnt + 1'b1;
          end
        end
        ST_LOCKED: begin
          err_now = mismatch;
          // Loss takes priority over a window wrap on the same bit.
          if (win_err_sum >= WE_W'(LOSS_THRESH)) begin
            state_nxt   = ST_HUNT;
            win_cnt_nxt = '0;
            win_err_nxt = '0;
          end else if (win_cnt == WC_W'(LOSS_WIN - 1)) begin
            win_cnt_nxt = '0;
            win_err_nxt = '0;
          end else begin
            win_cnt_nxt = win_cnt + 1'b1;
            win_err_nxt = win_err_sum;
          end
        end
        default: state_nxt = ST_HUNT;
      endcase
    end
  end

  // ---- register stage: state, history, counters, outputs ----
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= ST_HUNT;
      sr        <= '0;
      seed_cnt  <= '0;
      vcnt      <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      sr        <= sr_nxt;
      seed_cnt  <= seed_nxt;
      vcnt      <= vcnt_nxt;
      win_cnt   <= win_cnt_nxt;
      win_err   <= win_err_nxt;
      locked    <= (state_nxt == ST_LOCKED);
      err_pulse <= err_now;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n || clr_cnt) begin
      err_cnt <= '0;
    end else if (err_now && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

`ifdef PRBS31_CHK_BITCNT_EN
  logic [31:0] bit_cnt_q;

  always_ff @(posedge clk) begin
    if (rst_n || clr_cnt) begin
      bit_cnt_q <= '0;
    end else if (din_valid && (state == ST_LOCKED)) begin
      bit_cnt_q <= bit_cnt_q + 1'b1;
    end
  end

  assign bit_cnt = bit_cnt_q;
`else
  assign bit_cnt = 32'd0;
`endif

endmodule
